// File: rtl/pipe_buf_pkg.sv
// Shared types and default widths for the inter-stage pipeline buffer.
package pipe_buf_pkg;

    localparam int CTRL_W_DEF = 14;
    localparam int DATA_W_DEF = 48;
    localparam int PC_W_DEF   = 32;
    localparam int CNT_W_DEF  = 16;

    // The encoding doubles as the occupancy count driven out of the buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/pipe_buf_perf_ctr.sv
// Saturating event counter used for the buffer's optional performance statistics.
module pipe_buf_perf_ctr #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r;

    // Count events, holding at all-ones once reached.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/pipe_stage_buffer.sv
// Two-entry skid buffer between pipeline stages with flush-to-bubble.
// Optional stall/squash counters are built when PIPE_BUF_PERF_EN is defined.
module pipe_stage_buffer
    import pipe_buf_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF
`ifdef PIPE_BUF_PERF_EN
    ,
    parameter int CNT_W  = CNT_W_DEF
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              in_irq,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic              out_irq,
    output logic [1:0]        occupancy
`ifdef PIPE_BUF_PERF_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  squash_cnt
`endif
);

    localparam int ENT_W = CTRL_W + DATA_W + PC_W + 1;

    occ_state_e       state_r;
    occ_state_e       next_state_s;
    logic [ENT_W-1:0] head_r;
    logic [ENT_W-1:0] skid_r;
    logic [ENT_W-1:0] in_ent_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             in_fire_s;
    logic             out_fire_s;

    // Entry layout, MSB first: ctrl, data, pc, irq.
    assign in_ent_s    = {in_ctrl, in_data, in_pc, in_irq};
    assign in_ready_s  = (state_r != FULL);
    assign out_valid_s = (state_r != EMPTY);
    assign in_fire_s   = in_valid & in_ready_s;
    assign out_fire_s  = out_valid_s & out_ready;

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMPTY;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next occupancy; flush overrides any transfer in the same cycle.
    always_comb begin
        next_state_s = state_r;
        if (flush) begin
            next_state_s = EMPTY;
        end else begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) next_state_s = ONE;
                    else           next_state_s = EMPTY;
                end
                ONE: begin
                    if (in_fire_s && !out_fire_s)      next_state_s = FULL;
                    else if (!in_fire_s && out_fire_s) next_state_s = EMPTY;
                    else                               next_state_s = ONE;
                end
                FULL: begin
                    if (out_fire_s) next_state_s = ONE;
                    else            next_state_s = FULL;
                end
                default: next_state_s = EMPTY;
            endcase
        end
    end

    // Head/skid storage; a flushed cycle leaves contents stale since they are masked as bubbles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r <= {ENT_W{1'b0}};
            skid_r <= {ENT_W{1'b0}};
        end else if (!flush) begin
            case (state_r)
                EMPTY: begin
                    if (in_fire_s) head_r <= in_ent_s;
                end
                ONE: begin
                    if (in_fire_s && out_fire_s) head_r <= in_ent_s;
                    else if (in_fire_s)          skid_r <= in_ent_s;
                end
                FULL: begin
                    if (out_fire_s) head_r <= skid_r;
                end
                default: begin
                    head_r <= head_r;
                    skid_r <= skid_r;
                end
            endcase
        end
    end

    // Outputs derive from registered state only; control and irq are forced to bubble when empty.
    always_comb begin
        in_ready  = in_ready_s;
        out_valid = out_valid_s;
        occupancy = state_r;
        out_data  = head_r[PC_W+1 +: DATA_W];
        out_pc    = head_r[1 +: PC_W];
        if (out_valid_s) begin
            out_ctrl = head_r[ENT_W-1 -: CTRL_W];
            out_irq  = head_r[0];
        end else begin
            out_ctrl = {CTRL_W{1'b0}};
            out_irq  = 1'b0;
        end
    end

`ifdef PIPE_BUF_PERF_EN
    logic stall_inc_s;
    logic squash_inc_s;

    assign stall_inc_s  = in_valid & ~in_ready_s;
    assign squash_inc_s = flush & (state_r != EMPTY);

    pipe_buf_perf_ctr #(.CNT_W(CNT_W)) u_stall_ctr (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc_s),
        .cnt (stall_cnt)
    );

    pipe_buf_perf_ctr #(.CNT_W(CNT_W)) u_squash_ctr (
        .clk (clk),
        .rst (rst),
        .inc (squash_inc_s),
        .cnt (squash_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: directed table, random traffic against a queue model, async reset.
module tb_pipe_stage_buffer;

    localparam int CTRL_W = 14;
    localparam int DATA_W = 48;
    localparam int PC_W   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic [PC_W-1:0]   in_pc = '0;
    logic              in_irq = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [PC_W-1:0]   out_pc;
    logic              out_irq;
    logic [1:0]        occupancy;
`ifdef PIPE_BUF_PERF_EN
    logic [3:0]        stall_cnt;
    logic [3:0]        squash_cnt;
`endif

    always #5 clk = ~clk;

`ifdef PIPE_BUF_PERF_EN
    pipe_stage_buffer #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_W(PC_W), .CNT_W(4)) dut (
`else
    pipe_stage_buffer #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .PC_W(PC_W)) dut (
`endif
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
        .in_data(in_data), .in_pc(in_pc), .in_irq(in_irq),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl),
        .out_data(out_data), .out_pc(out_pc), .out_irq(out_irq),
        .occupancy(occupancy)
`ifdef PIPE_BUF_PERF_EN
        , .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
`endif
    );

    typedef struct {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic [PC_W-1:0]   pc;
        logic              irq;
    } ent_t;

    typedef struct {
        string             name;
        logic              v;
        logic              rdy;
        logic              fl;
        logic [CTRL_W-1:0] ctrl;
        logic [PC_W-1:0]   pc;
        logic              irq;
        logic              e_valid;
        logic [CTRL_W-1:0] e_ctrl;
        logic              e_ready;
        logic [1:0]        e_occ;
    } vec_t;

    ent_t q[$];
    vec_t tbl[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic v, input logic rdy, input logic fl, input logic [CTRL_W-1:0] c,
                         input logic [DATA_W-1:0] d, input logic [PC_W-1:0] p, input logic i);
        in_valid = v; out_ready = rdy; flush = fl;
        in_ctrl = c; in_data = d; in_pc = p; in_irq = i;
    endtask

    // Reference: a FIFO of at most two entries; flush empties it, pop happens before push.
    task automatic tick();
        int   sz;
        bit   ofire;
        bit   ifire;
        ent_t e;
        sz    = q.size();
        ofire = (sz > 0) && out_ready;
        ifire = in_valid && (sz < 2);
        e.ctrl = in_ctrl; e.data = in_data; e.pc = in_pc; e.irq = in_irq;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (ofire) q.delete(0);
            if (ifire) q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic check_model();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        chk("occupancy", occupancy, q.size());
        if (q.size() > 0) begin
            chk("out_ctrl", out_ctrl, q[0].ctrl);
            chk("out_data", out_data, q[0].data);
            chk("out_pc", out_pc, q[0].pc);
            chk("out_irq", out_irq, q[0].irq);
        end else begin
            chk("bubble_ctrl", out_ctrl, 0);
            chk("bubble_irq", out_irq, 0);
        end
    endtask

    function automatic vec_t mk(input string n, input logic v, input logic rdy, input logic fl,
                                input logic [CTRL_W-1:0] c, input logic [PC_W-1:0] p, input logic i,
                                input logic ev, input logic [CTRL_W-1:0] ec, input logic er,
                                input logic [1:0] eo);
        vec_t t;
        t.name = n; t.v = v; t.rdy = rdy; t.fl = fl; t.ctrl = c; t.pc = p; t.irq = i;
        t.e_valid = ev; t.e_ctrl = ec; t.e_ready = er; t.e_occ = eo;
        return t;
    endfunction

    task automatic check_zero_outputs(input string tag);
        chk({tag, "/out_valid"}, out_valid, 0);
        chk({tag, "/out_ctrl"}, out_ctrl, 0);
        chk({tag, "/out_data"}, out_data, 0);
        chk({tag, "/out_pc"}, out_pc, 0);
        chk({tag, "/out_irq"}, out_irq, 0);
        chk({tag, "/occupancy"}, occupancy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Stream 8 entries with the sink always ready, then drain.
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk("stream", 1'b1, 1'b1, 1'b0, CTRL_W'(i + 1), PC_W'(32'h100 + 4 * i),
                             1'(i % 2), 1'b1, CTRL_W'(i + 1), 1'b1, 2'd1));
        end
        tbl.push_back(mk("drain", 1'b0, 1'b1, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 1'b1, 2'd0));
        // Back-pressure: third entry refused until the sink releases.
        tbl.push_back(mk("bp_0x11", 1'b1, 1'b0, 1'b0, 14'h11, 32'h200, 1'b0, 1'b1, 14'h11, 1'b1, 2'd1));
        tbl.push_back(mk("bp_0x22", 1'b1, 1'b0, 1'b0, 14'h22, 32'h204, 1'b1, 1'b1, 14'h11, 1'b0, 2'd2));
        tbl.push_back(mk("bp_0x33", 1'b1, 1'b0, 1'b0, 14'h33, 32'h208, 1'b0, 1'b1, 14'h11, 1'b0, 2'd2));
        tbl.push_back(mk("rel_0x22", 1'b1, 1'b1, 1'b0, 14'h33, 32'h208, 1'b0, 1'b1, 14'h22, 1'b1, 2'd1));
        tbl.push_back(mk("rel_0x33", 1'b1, 1'b1, 1'b0, 14'h33, 32'h208, 1'b0, 1'b1, 14'h33, 1'b1, 2'd1));
        tbl.push_back(mk("rel_done", 1'b0, 1'b1, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 1'b1, 2'd0));
        // Flush while full, with an entry offered in the same cycle.
        tbl.push_back(mk("fill_a", 1'b1, 1'b0, 1'b0, 14'h01, 32'h300, 1'b1, 1'b1, 14'h01, 1'b1, 2'd1));
        tbl.push_back(mk("fill_b", 1'b1, 1'b0, 1'b0, 14'h02, 32'h304, 1'b1, 1'b1, 14'h01, 1'b0, 2'd2));
        tbl.push_back(mk("flush", 1'b1, 1'b0, 1'b1, 14'h3FFF, 32'h308, 1'b1, 1'b0, 14'h0, 1'b1, 2'd0));
        tbl.push_back(mk("post_flush", 1'b0, 1'b1, 1'b0, 14'h0, 32'h0, 1'b0, 1'b0, 14'h0, 1'b1, 2'd0));

        // Reset state, sampled while reset is still asserted.
        @(negedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_model();

        foreach (tbl[k]) begin
            drive(tbl[k].v, tbl[k].rdy, tbl[k].fl, tbl[k].ctrl,
                  {tbl[k].pc, 2'b10, tbl[k].ctrl}, tbl[k].pc, tbl[k].irq);
            tick();
            check_model();
            chk({tbl[k].name, "/out_valid"}, out_valid, tbl[k].e_valid);
            chk({tbl[k].name, "/out_ctrl"}, out_ctrl, tbl[k].e_ctrl);
            chk({tbl[k].name, "/in_ready"}, in_ready, tbl[k].e_ready);
            chk({tbl[k].name, "/occupancy"}, occupancy, tbl[k].e_occ);
        end

        // Random traffic with an asynchronous reset landing between edges.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
                  CTRL_W'($urandom), {16'($urandom), 32'($urandom)}, PC_W'($urandom), 1'($urandom));
            if (n == 200) begin
                #2 rst = 1'b1;
                #1 check_zero_outputs("async_rst");
                q.delete();
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk("post_rst/occupancy", occupancy, 0);
                chk("post_rst/in_ready", in_ready, 1);
            end else begin
                tick();
                check_model();
            end
        end

`ifdef PIPE_BUF_PERF_EN
        // Counters: stall saturation, then squash counting only occupied flushes.
        drive(1'b0, 1'b0, 1'b0, 14'h0, 48'h0, 32'h0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        for (int n = 0; n < 22; n++) begin
            drive(1'b1, 1'b0, 1'b0, CTRL_W'(n), 48'(n), PC_W'(n), 1'b0);
            tick();
            check_model();
        end
        chk("stall_cnt_sat", stall_cnt, 4'hF);
        drive(1'b0, 1'b0, 1'b1, 14'h0, 48'h0, 32'h0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 14'h5, 48'h5, 32'h5, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 14'h0, 48'h0, 32'h0, 1'b0);
        tick();
        tick();
        check_model();
        chk("squash_cnt", squash_cnt, 4'h2);
        chk("stall_cnt_after_flush", stall_cnt, 4'hF);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
